// File: rtl/goertzel_multibin_engine.sv
`default_nettype none
// ============================================================================
// Module      : goertzel_multibin_engine
// Description : Time-multiplexed multi-bin Goertzel DFT engine. One shared MAC
//               walks BIN_NUM programmable bins per input sample, then emits a
//               complex, scaled and saturated result per bin on a valid/ready
//               stream.
// Revision    : 1.0 - initial release
// ============================================================================
module goertzel_multibin_engine #(
    parameter  int WIDTH      = 12,
    parameter  int N_MAX      = 32768,
    parameter  int BIN_NUM    = 64,
    parameter  int COEF_WIDTH = 16,
    parameter  int FRAC_BITS  = 14,
    localparam int LOG_N_MAX  = $clog2(N_MAX),
    localparam int BIN_W      = $clog2(BIN_NUM),
    localparam int LOGN_W     = $clog2(LOG_N_MAX + 1)
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic                  i_cfg_we,
    input  logic [BIN_W-1:0]      i_cfg_bin,
    input  logic [COEF_WIDTH-1:0] i_cfg_cos2,
    input  logic [COEF_WIDTH-1:0] i_cfg_sin,
    input  logic                  i_start,
    input  logic [LOGN_W-1:0]     i_log_n,
    input  logic [WIDTH-1:0]      i_x,
    input  logic                  i_wr,
    output logic                  o_ready,
    output logic [WIDTH-1:0]      o_y_re,
    output logic [WIDTH-1:0]      o_y_im,
    output logic [BIN_W-1:0]      o_bin,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_done
);

    localparam int ACC_W  = WIDTH + LOG_N_MAX + 2;
    localparam int PROD_W = ACC_W + COEF_WIDTH;
    localparam int CNT_W  = LOG_N_MAX;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_UPD  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q;
    logic [BIN_W-1:0]         bin_q;
    logic [LOGN_W-1:0]        log_n_q;
    logic signed [WIDTH-1:0]  x_q;
    logic                     launch_q, p_vld_q;
    logic signed [PROD_W-1:0] p_re_q, p_im_q;
    logic                     o_valid_q, o_done_q;
    logic [BIN_W-1:0]         o_bin_q;
    logic [WIDTH-1:0]         o_y_re_q, o_y_im_q;

    logic signed [COEF_WIDTH-1:0] cos2_mem [BIN_NUM];
    logic signed [COEF_WIDTH-1:0] sin_mem  [BIN_NUM];
    logic signed [ACC_W-1:0]      s1_mem   [BIN_NUM];
    logic signed [ACC_W-1:0]      s2_mem   [BIN_NUM];

    logic signed [COEF_WIDTH-1:0] w_cos2, w_sin, w_c2h;
    logic signed [ACC_W-1:0]      w_s1, w_s2, w_s0;
    logic signed [PROD_W-1:0]     w_fb, w_p_re, w_p_im, w_rnd, w_re_r, w_im_r;
    logic                         w_first, w_bin_last, w_cnt_last, w_hs;
    logic [CNT_W:0]               w_n;
    logic [LOGN_W-1:0]            w_log_n_cl;

    // Clamp a result to the signed WIDTH range instead of letting it wrap.
    function automatic logic [WIDTH-1:0] f_sat(input logic signed [PROD_W-1:0] v);
        logic [PROD_W-WIDTH:0] top;
        top = v[PROD_W-1:WIDTH-1];
        if ((&top) || !(|top))
            f_sat = v[WIDTH-1:0];
        else if (v[PROD_W-1])
            f_sat = {1'b1, {(WIDTH-1){1'b0}}};
        else
            f_sat = {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    assign w_cos2 = cos2_mem[bin_q];
    assign w_sin  = sin_mem[bin_q];
    assign w_c2h  = w_cos2 >>> 1;

    // First sample of a frame sees zero history, which replaces a clear pass.
    assign w_first = (state_q == S_UPD) && (cnt_q == '0);
    assign w_s1    = w_first ? '0 : s1_mem[bin_q];
    assign w_s2    = w_first ? '0 : s2_mem[bin_q];

    // Recursion: s0 = x + floor(cos2*s1 / 2^F) - s2, wrapping at ACC_W.
    assign w_fb = (PROD_W'(w_cos2) * PROD_W'(w_s1)) >>> FRAC_BITS;
    assign w_s0 = ACC_W'(PROD_W'(x_q) + w_fb - PROD_W'(w_s2));

    // Final complex term: re = s1 - cos*s2, im = sin*s2.
    assign w_p_re = PROD_W'(w_s1) - ((PROD_W'(w_c2h) * PROD_W'(w_s2)) >>> FRAC_BITS);
    assign w_p_im = (PROD_W'(w_sin) * PROD_W'(w_s2)) >>> FRAC_BITS;

    // Divide by N with round-half-up.
    assign w_rnd  = (log_n_q == '0) ? '0 : (PROD_W'(1) << (log_n_q - LOGN_W'(1)));
    assign w_re_r = (p_re_q + w_rnd) >>> log_n_q;
    assign w_im_r = (p_im_q + w_rnd) >>> log_n_q;

    assign w_log_n_cl = (i_log_n > LOGN_W'(LOG_N_MAX)) ? LOGN_W'(LOG_N_MAX) : i_log_n;
    assign w_n        = (CNT_W+1)'(1) << log_n_q;
    assign w_cnt_last = (cnt_q == CNT_W'(w_n - (CNT_W+1)'(1)));
    assign w_bin_last = (bin_q == BIN_W'(BIN_NUM - 1));
    assign w_hs       = o_valid_q && i_ready;

    // Next-state selection for the frame sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_WAIT;
            S_WAIT:  if (i_wr) state_d = S_UPD;
            S_UPD:   if (w_bin_last) state_d = w_cnt_last ? S_OUT : S_WAIT;
            S_OUT:   if (w_hs && w_bin_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Coefficient RAM: writable only while idle, never cleared by reset.
    always_ff @(posedge i_sys_clk) begin
        if (state_q == S_IDLE && i_cfg_we) begin
            cos2_mem[i_cfg_bin] <= i_cfg_cos2;
            sin_mem[i_cfg_bin]  <= i_cfg_sin;
        end
    end

    // Per-bin recursion state: shift s1 into s2 and store the new s0.
    always_ff @(posedge i_sys_clk) begin
        if (state_q == S_UPD) begin
            s1_mem[bin_q] <= w_s0;
            s2_mem[bin_q] <= w_s1;
        end
    end

    // Frame control, sample capture and the two-stage output pipeline.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bin_q     <= '0;
            log_n_q   <= '0;
            x_q       <= '0;
            launch_q  <= 1'b0;
            p_vld_q   <= 1'b0;
            p_re_q    <= '0;
            p_im_q    <= '0;
            o_valid_q <= 1'b0;
            o_done_q  <= 1'b0;
            o_bin_q   <= '0;
            o_y_re_q  <= '0;
            o_y_im_q  <= '0;
        end else begin
            state_q  <= state_d;
            o_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        log_n_q <= w_log_n_cl;
                        cnt_q   <= '0;
                    end
                end
                S_WAIT: begin
                    if (i_wr) begin
                        x_q   <= i_x;
                        bin_q <= '0;
                    end
                end
                S_UPD: begin
                    if (w_bin_last) begin
                        if (w_cnt_last) begin
                            bin_q    <= '0;
                            launch_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end else begin
                        bin_q <= bin_q + BIN_W'(1);
                    end
                end
                S_OUT: begin
                    if (launch_q) begin
                        p_re_q   <= w_p_re;
                        p_im_q   <= w_p_im;
                        p_vld_q  <= 1'b1;
                        launch_q <= 1'b0;
                    end
                    if (p_vld_q) begin
                        o_y_re_q  <= f_sat(w_re_r);
                        o_y_im_q  <= f_sat(w_im_r);
                        o_bin_q   <= bin_q;
                        o_valid_q <= 1'b1;
                        p_vld_q   <= 1'b0;
                    end
                    if (w_hs) begin
                        o_valid_q <= 1'b0;
                        if (w_bin_last) begin
                            o_done_q <= 1'b1;
                        end else begin
                            bin_q    <= bin_q + BIN_W'(1);
                            launch_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ready = (state_q == S_WAIT);
    assign o_valid = o_valid_q;
    assign o_done  = o_done_q;
    assign o_bin   = o_bin_q;
    assign o_y_re  = o_y_re_q;
    assign o_y_im  = o_y_im_q;

endmodule
`default_nettype wire

// File: tb/tb_goertzel_multibin_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_goertzel_multibin_engine
// Description : Self-checking bench for goertzel_multibin_engine: frame table
//               with spectral targets, bit-exact scoreboard, back-pressure,
//               mid-frame reset and coefficient-write ordering sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_goertzel_multibin_engine;

    localparam int WIDTH     = 12;
    localparam int N_MAX     = 64;
    localparam int BIN_NUM   = 4;
    localparam int CW        = 16;
    localparam int FB        = 13;
    localparam int LOG_N_MAX = $clog2(N_MAX);
    localparam int BIN_W     = $clog2(BIN_NUM);
    localparam int LOGN_W    = $clog2(LOG_N_MAX + 1);
    localparam int ACC_W     = WIDTH + LOG_N_MAX + 2;
    localparam int MAXV      = (1 << (WIDTH - 1)) - 1;
    localparam int MINV      = -(1 << (WIDTH - 1));

    logic clk = 1'b0;
    logic rst;
    logic i_cfg_we, i_start, i_wr, i_ready;
    logic [BIN_W-1:0] i_cfg_bin;
    logic [CW-1:0] i_cfg_cos2, i_cfg_sin;
    logic [LOGN_W-1:0] i_log_n;
    logic [WIDTH-1:0] i_x;
    logic o_ready, o_valid, o_done;
    logic [WIDTH-1:0] o_y_re, o_y_im;
    logic [BIN_W-1:0] o_bin;

    goertzel_multibin_engine #(
        .WIDTH(WIDTH), .N_MAX(N_MAX), .BIN_NUM(BIN_NUM),
        .COEF_WIDTH(CW), .FRAC_BITS(FB)
    ) dut (
        .i_sys_clk(clk), .i_sys_rst(rst),
        .i_cfg_we(i_cfg_we), .i_cfg_bin(i_cfg_bin),
        .i_cfg_cos2(i_cfg_cos2), .i_cfg_sin(i_cfg_sin),
        .i_start(i_start), .i_log_n(i_log_n),
        .i_x(i_x), .i_wr(i_wr), .o_ready(o_ready),
        .o_y_re(o_y_re), .o_y_im(o_y_im), .o_bin(o_bin),
        .o_valid(o_valid), .i_ready(i_ready), .o_done(o_done)
    );

    always #5 clk = ~clk;

    typedef struct { int bin; int re; int im; } exp_t;
    typedef struct {
        int cfg; int ln; int dc; int amp; int bin; int mode; int ere; int eim; int tol;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[5];
    int samp[N_MAX];
    int c2m[BIN_NUM], snm[BIN_NUM];
    int got_re[BIN_NUM], got_im[BIN_NUM], ref_re[BIN_NUM], ref_im[BIN_NUM];
    int checks = 0, errors = 0;
    int done_cnt = 0, frames = 0;

    always @(negedge clk) if (o_done) done_cnt++;

    task automatic chk(input string nm, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int rsat(input longint v, input int ln);
        longint r;
        r = v;
        if (ln > 0) r = (v + (64'sd1 <<< (ln - 1))) >>> ln;
        if (r > MAXV) r = MAXV;
        if (r < MINV) r = MINV;
        return int'(r);
    endfunction

    // Reference Goertzel frame over samp[] with the model's coefficient copy.
    task automatic model_frame(input int ln);
        longint s0, s1, s2, re, im;
        exp_t e;
        for (int b = 0; b < BIN_NUM; b++) begin
            s1 = 0; s2 = 0;
            for (int n = 0; n < (1 << ln); n++) begin
                s0 = longint'(samp[n]) + ((longint'(c2m[b]) * s1) >>> FB) - s2;
                s0 = (s0 <<< (64 - ACC_W)) >>> (64 - ACC_W);
                s2 = s1; s1 = s0;
            end
            re = s1 - ((longint'(c2m[b] >>> 1) * s2) >>> FB);
            im = (longint'(snm[b]) * s2) >>> FB;
            e.bin = b; e.re = rsat(re, ln); e.im = rsat(im, ln);
            exp_q.push_back(e);
        end
    endtask

    task automatic gen(input int dc, input int amp, input int ln);
        for (int n = 0; n < (1 << ln); n++)
            samp[n] = dc ? amp : ((n % 4 == 0) ? amp : ((n % 4 == 2) ? -amp : 0));
    endtask

    task automatic cfg_write(input int b, input int c, input int s);
        @(negedge clk);
        i_cfg_we = 1'b1; i_cfg_bin = BIN_W'(b); i_cfg_cos2 = CW'(c); i_cfg_sin = CW'(s);
        @(negedge clk);
        i_cfg_we = 1'b0;
        c2m[b] = c; snm[b] = s;
    endtask

    task automatic load_cfg(input int cfg);
        cfg_write(0, 16384, 0);
        if (cfg == 0) begin
            cfg_write(1, 15137, 3135);
            cfg_write(2, 11585, 5793);
        end else begin
            cfg_write(1, 0, 32767);
            cfg_write(2, 0, -32768);
        end
        cfg_write(3, 0, 8192);
    endtask

    task automatic start_frame(input int ln);
        @(negedge clk);
        i_start = 1'b1; i_log_n = LOGN_W'(ln);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic feed(input int count, input bit junk);
        int g;
        for (int n = 0; n < count; n++) begin
            g = 0;
            while (!o_ready && g < 200) begin @(negedge clk); g++; end
            if (!o_ready) begin
                chk("ready_timeout", 1'b0, 0, 1);
                return;
            end
            i_wr = 1'b1; i_x = WIDTH'(samp[n]);
            @(negedge clk);
            i_wr = 1'b0;
            if (junk) begin
                i_wr = 1'b1; i_x = WIDTH'(1234);
                @(negedge clk);
                i_wr = 1'b0;
            end
        end
    endtask

    task automatic collect(input int stall_bin);
        int guard, sre, sim, sbin;
        bit stalled;
        exp_t e;
        guard = 0; stalled = 1'b0; i_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 3000) begin
            @(negedge clk); guard++;
            if (o_valid) begin
                if (int'(o_bin) == stall_bin && !stalled) begin
                    stalled = 1'b1; i_ready = 1'b0;
                    sre = int'(o_y_re); sim = int'(o_y_im); sbin = int'(o_bin);
                    for (int k = 0; k < 20; k++) begin
                        @(negedge clk);
                        chk("stall_hold", o_valid && int'(o_y_re) == sre &&
                            int'(o_y_im) == sim && int'(o_bin) == sbin, int'(o_y_re), sre);
                    end
                    i_ready = 1'b1;
                end
                e = exp_q.pop_front();
                chk("out_bin", int'(o_bin) == e.bin, int'(o_bin), e.bin);
                chk("out_re", int'($signed(o_y_re)) == e.re, int'($signed(o_y_re)), e.re);
                chk("out_im", int'($signed(o_y_im)) == e.im, int'($signed(o_y_im)), e.im);
                chk("done_early", o_done == 1'b0, int'(o_done), 0);
                got_re[o_bin] = int'($signed(o_y_re));
                got_im[o_bin] = int'($signed(o_y_im));
                if (exp_q.size() == 0) begin
                    @(negedge clk);
                    chk("done_pulse", o_done == 1'b1, int'(o_done), 1);
                    @(negedge clk);
                    chk("done_clear", o_done == 1'b0, int'(o_done), 0);
                    frames++;
                end
            end
        end
        if (exp_q.size() > 0) begin
            chk("output_timeout", 1'b0, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic run_frame(input int ln, input bit junk, input int stall_bin);
        start_frame(ln);
        model_frame(ln);
        feed(1 << ln, junk);
        collect(stall_bin);
    endtask

    initial begin
        // cfg, ln, dc, amp, bin, mode(0 exact-ish,1 |re|+|im|,2 leakage), ere, eim, tol
        tbl[0] = '{0, 4, 0, 1000, 3, 1, 500, 0, 1};
        tbl[1] = '{0, 4, 0, 1000, 2, 2, 0, 0, 2};
        tbl[2] = '{0, 3, 1, 100, 0, 0, 100, 0, 1};
        tbl[3] = '{1, 6, 0, 2047, 1, 0, 0, -2048, 0};
        tbl[4] = '{1, 6, 0, 2047, 2, 0, 0, 2047, 0};

        rst = 1'b1; i_cfg_we = 1'b0; i_cfg_bin = '0; i_cfg_cos2 = '0; i_cfg_sin = '0;
        i_start = 1'b0; i_log_n = '0; i_x = '0; i_wr = 1'b0; i_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", o_ready == 1'b0, int'(o_ready), 0);
        chk("rst_valid", o_valid == 1'b0, int'(o_valid), 0);
        chk("rst_done", o_done == 1'b0, int'(o_done), 0);
        chk("rst_bin", o_bin == '0, int'(o_bin), 0);
        chk("rst_re", o_y_re == '0, int'(o_y_re), 0);
        chk("rst_im", o_y_im == '0, int'(o_y_im), 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            load_cfg(tbl[i].cfg);
            gen(tbl[i].dc, tbl[i].amp, tbl[i].ln);
            run_frame(tbl[i].ln, i == 0, -1);
            case (tbl[i].mode)
                0: begin
                    chk("tbl_re", iabs(got_re[tbl[i].bin] - tbl[i].ere) <= tbl[i].tol,
                        got_re[tbl[i].bin], tbl[i].ere);
                    chk("tbl_im", iabs(got_im[tbl[i].bin] - tbl[i].eim) <= tbl[i].tol,
                        got_im[tbl[i].bin], tbl[i].eim);
                end
                1: chk("tbl_mag", iabs(iabs(got_re[tbl[i].bin]) + iabs(got_im[tbl[i].bin])
                        - tbl[i].ere) <= tbl[i].tol,
                        iabs(got_re[tbl[i].bin]) + iabs(got_im[tbl[i].bin]), tbl[i].ere);
                default: chk("tbl_leak", iabs(got_re[tbl[i].bin]) + iabs(got_im[tbl[i].bin])
                        <= tbl[i].tol,
                        iabs(got_re[tbl[i].bin]) + iabs(got_im[tbl[i].bin]), tbl[i].tol);
            endcase
            if (i == 0) begin
                ref_re = got_re;
                ref_im = got_im;
            end
        end

        // Back-pressure: hold i_ready low for 20 cycles on bin 1.
        load_cfg(0);
        gen(0, 1000, 4);
        run_frame(4, 1'b0, 1);

        // Abort a frame after 5 samples with reset, then rerun it cleanly.
        gen(0, 700, 4);
        start_frame(4);
        feed(5, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", o_ready == 1'b0, int'(o_ready), 0);
        chk("abort_valid", o_valid == 1'b0, int'(o_valid), 0);
        repeat (5) @(negedge clk);
        chk("abort_no_done", done_cnt == frames, done_cnt, frames);
        gen(0, 1000, 4);
        run_frame(4, 1'b0, -1);
        for (int b = 0; b < BIN_NUM; b++) begin
            chk("abort_ref_re", got_re[b] == ref_re[b], got_re[b], ref_re[b]);
            chk("abort_ref_im", got_im[b] == ref_im[b], got_im[b], ref_im[b]);
        end

        // Coefficient write together with start lands first; a write and a
        // start issued during WAIT are ignored.
        gen(0, 900, 4);
        @(negedge clk);
        i_cfg_we = 1'b1; i_cfg_bin = BIN_W'(2); i_cfg_cos2 = CW'(-8192); i_cfg_sin = CW'(4000);
        i_start = 1'b1; i_log_n = LOGN_W'(4);
        @(negedge clk);
        i_cfg_we = 1'b0; i_start = 1'b0;
        c2m[2] = -8192; snm[2] = 4000;
        model_frame(4);
        i_cfg_we = 1'b1; i_cfg_bin = BIN_W'(2); i_cfg_cos2 = CW'(8000); i_cfg_sin = CW'(-7000);
        i_start = 1'b1; i_log_n = LOGN_W'(2);
        @(negedge clk);
        i_cfg_we = 1'b0; i_start = 1'b0;
        feed(16, 1'b0);
        collect(-1);
        gen(0, 600, 3);
        run_frame(3, 1'b0, -1);

        chk("done_count", done_cnt == frames, done_cnt, frames);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
